reg_writeback_unit: RTL and testbench
=====================================

// Module: reg_writeback_unit
// PURPOSE
//  Writer side of the 8x16 register-file write port (wr_en/wr_dest/wr_data).
//  Accepts write-back requests from the ALU and memory-load paths (valid/ready),
//  arbitrates round-robin, buffers them in a small FIFO, and issues exactly one
//  single-cycle write pulse per request. Publishes a per-register pending mask
//  so decode can stall reads of registers with writes still in flight.
// PARAMETERS
//  DATA_W      16  register data width
//  ADDR_W      3   register address width (NUM_REGS = 2**ADDR_W = 8)
//  FIFO_DEPTH  4   buffered requests; power of 2, >= 2
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous reset, active-high
//  clock_enable  in   1        0 = freeze all state except wr_en (see below)
//  alu_valid     in   1        ALU request valid
//  alu_ready     out  1        ALU request accepted this cycle
//  alu_dest      in   ADDR_W   ALU destination register
//  alu_data      in   DATA_W   ALU result
//  mem_valid     in   1        load request valid
//  mem_ready     out  1        load request accepted this cycle
//  mem_dest      in   ADDR_W   load destination register
//  mem_data      in   DATA_W   load data
//  wb_hold       in   1        1 = do not pop the FIFO this cycle
//  wr_en         out  1        register-file write enable (registered)
//  wr_dest       out  ADDR_W   register-file write address (registered)
//  wr_data       out  DATA_W   register-file write data (registered)
//  pend_mask     out  NUM_REGS bit i = write to reg i in FIFO or on wr_* port
//  fifo_count    out  ADDR_W+1 occupancy 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset: wr_en=0, wr_dest=0, wr_data=0, pend_mask=0, fifo_count=0, FIFO
//   flushed, last_grant=MEM (ALU wins first tie). Reset mid-operation drops all
//   queued/in-flight writes; wr_en=0 in the cycle after the reset edge.
//  Handshake: transfer when x_valid & x_ready at a rising edge; source holds
//   valid/dest/data stable until accepted. x_ready is combinational:
//   x_ready = clock_enable & !rst & grant_x & (fifo_count < FIFO_DEPTH).
//  Arbitration: one push per cycle max. Only one valid -> it is granted. Both
//   valid -> grant the source not in last_grant; last_grant updates on push.
//  Pop: when clock_enable & !wb_hold & fifo_count>0, head moves into wr_* and
//   wr_en=1 for exactly the next cycle; otherwise wr_en=0 next cycle (wr_dest/
//   wr_data hold). Register file ignores clock_enable, so wr_en never stays
//   high for more than one cycle per entry.
//  Latency: accept at edge E -> pop at E+1 -> register file written at E+2.
//  Full: both readies low; push and pop in same cycle when full -> pop only.
//  Push+pop same cycle (not full): count unchanged; pointers wrap mod DEPTH.
//  Pending: per-register counter (width clog2(FIFO_DEPTH+2)); +1 on push to
//   dest, -1 at the edge where wr_en=1 for that dest; both on same reg in one
//   cycle -> unchanged. pend_mask[i] = (cnt[i] != 0). Duplicate dests allowed;
//   writes land in acceptance order.
//  clock_enable=0: no push, no pop, FIFO/counters hold, wr_en forced 0.
// STRUCTURE
//  Shared header reg_defs.vh: DATA_W, ADDR_W, NUM_REGS, SRC_ALU=1'b0,
//   SRC_MEM=1'b1. Sub-module: wb_fifo (sync FIFO, push/pop/full/empty/count,
//   {dest,data} entries). Arbiter, pending counters, output regs stay top-level.
// TESTING
//  1 ALU only: alu_dest=3,data=16'hBEEF accepted at E -> wr_en=1,dest=3,
//    data=BEEF in cycle after E+1 only; pend_mask=8'h08 from E to E+2, then 0.
//  2 Both valid for 4 cycles (ALU d1..d4, MEM m1..m4, wb_hold=1) -> pushes
//    alternate ALU,MEM,ALU,MEM; fifo_count=4; both readies 0 on 5th cycle.
//  3 Release wb_hold with FIFO full -> 4 consecutive wr_en pulses in push
//    order; pop-only cycle when full; fifo_count 4,3,2,1,0.
//  4 Two pushes to reg 5 (hold=1) -> pend_mask[5] stays 1 until second write
//    edge; last value written to reg 5 is the later request's data.
//  5 clock_enable=0 for 3 cycles with 2 queued -> wr_en=0, count=2, readies 0;
//    re-enable -> writes resume in order, no entry lost or duplicated.
//  6 rst asserted with count=3, wr_en=1 -> next cycle wr_en=0, count=0,
//    pend_mask=0; next ALU+MEM tie grants ALU.

Source files
------------

// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths, depths and source encoding for the register write-back path.
package reg_writeback_unit_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int NUM_REGS   = 2 ** ADDR_W;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding {dest,data} write-back entries.
module wb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Round-robin ALU/load write-back arbiter feeding the register-file write port.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int DATA_W     = reg_writeback_unit_pkg::DATA_W,
    parameter int ADDR_W     = reg_writeback_unit_pkg::ADDR_W,
    parameter int FIFO_DEPTH = reg_writeback_unit_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clock_enable,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_W-1:0]     alu_dest,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_W-1:0]     mem_dest,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  wb_hold,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_dest,
    output logic [DATA_W-1:0]     wr_data,
    output logic [2**ADDR_W-1:0]  pend_mask,
    output logic [ADDR_W:0]       fifo_count
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int EW    = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    src_e               last_grant_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_dest_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [CNT_W-1:0]   pend_cnt_q [NREG];
    logic [CNT_W-1:0]   pend_cnt_d [NREG];

    logic               grant_alu, grant_mem;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic [EW-1:0]      push_entry, head_entry;
    logic [FCW-1:0]     fifo_cnt;

    assign grant_alu = alu_valid & (~mem_valid | (last_grant_q == SRC_MEM));
    assign grant_mem = mem_valid & (~alu_valid | (last_grant_q == SRC_ALU));

    assign alu_ready = clock_enable & ~rst & grant_alu & ~fifo_full;
    assign mem_ready = clock_enable & ~rst & grant_mem & ~fifo_full;

    assign push       = alu_ready | mem_ready;
    assign push_entry = alu_ready ? {alu_dest, alu_data} : {mem_dest, mem_data};
    assign pop        = clock_enable & ~wb_hold & ~fifo_empty;

    wb_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // The write port ignores clock_enable so a popped entry is written once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_dest_q    <= '0;
            wr_data_q    <= '0;
            last_grant_q <= SRC_MEM;
        end else begin
            wr_en_q <= pop;
            if (pop) {wr_dest_q, wr_data_q} <= head_entry;
            if (push) last_grant_q <= alu_ready ? SRC_ALU : SRC_MEM;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d[i] = pend_cnt_q[i]
                + CNT_W'(push & (push_entry[EW-1:DATA_W] == ADDR_W'(i)))
                - CNT_W'(wr_en_q & (wr_dest_q == ADDR_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) pend_cnt_q[i] <= '0;
            else     pend_cnt_q[i] <= pend_cnt_d[i];
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREG; i++) pend_mask[i] = (pend_cnt_q[i] != '0);
    end

    assign wr_en      = wr_en_q;
    assign wr_dest    = wr_dest_q;
    assign wr_data    = wr_data_q;
    assign fifo_count = (ADDR_W+1)'(fifo_cnt);

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed vector table, corner sequences, random traffic.
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst, clock_enable, wb_hold;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [2:0]  alu_dest, mem_dest;
    logic [15:0] alu_data, mem_data;
    logic        wr_en;
    logic [2:0]  wr_dest;
    logic [15:0] wr_data;
    logic [7:0]  pend_mask;
    logic [3:0]  fifo_count;

    always #5 clk = ~clk;

    reg_writeback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .clock_enable (clock_enable),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_dest     (alu_dest),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_dest     (mem_dest),
        .mem_data     (mem_data),
        .wb_hold      (wb_hold),
        .wr_en        (wr_en),
        .wr_dest      (wr_dest),
        .wr_data      (wr_data),
        .pend_mask    (pend_mask),
        .fifo_count   (fifo_count)
    );

    typedef struct {
        bit rst, ce, hold, av;
        logic [2:0] ad; logic [15:0] adat;
        bit mv;
        logic [2:0] md; logic [15:0] mdat;
        bit er, em, ewen;
        logic [2:0] edest; logic [15:0] edata;
        logic [3:0] ecnt; logic [7:0] epend;
    } vec_t;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } ent_t;

    // Reference model: ordered queue of accepted writes plus the write port.
    ent_t        mq[$];
    bit          m_wen;
    logic [2:0]  m_wdest;
    logic [15:0] m_wdata;
    bit          m_lg_mem;
    logic [15:0] m_rf [8];
    logic [15:0] dut_rf [8];
    bit          last_a_acc, last_m_acc;

    int checks = 0;
    int failures = 0;
    vec_t tab[17];

    always @(posedge clk) begin
        if (wr_en === 1'b1) dut_rf[wr_dest] <= wr_data;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit h, bit av, int ad, int adat,
                                bit mv, int md, int mdat, bit er, bit em,
                                bit ew, int ed, int edat, int ec, int ep);
        vec_t v;
        v.rst = r; v.ce = 1'b1; v.hold = h;
        v.av = av; v.ad = 3'(ad); v.adat = 16'(adat);
        v.mv = mv; v.md = 3'(md); v.mdat = 16'(mdat);
        v.er = er; v.em = em; v.ewen = ew;
        v.edest = 3'(ed); v.edata = 16'(edat);
        v.ecnt = 4'(ec); v.epend = 8'(ep);
        return v;
    endfunction

    function automatic bit exp_ar();
        return clock_enable && !rst && alu_valid &&
               (!mem_valid || m_lg_mem) && (mq.size() < 4);
    endfunction

    function automatic bit exp_mr();
        return clock_enable && !rst && mem_valid &&
               (!alu_valid || !m_lg_mem) && (mq.size() < 4);
    endfunction

    function automatic logic [7:0] exp_pend();
        logic [7:0] m = '0;
        foreach (mq[i]) m[mq[i].dest] = 1'b1;
        if (m_wen) m[m_wdest] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wen = 0; m_wdest = '0; m_wdata = '0; m_lg_mem = 1;
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_edge(bit ar, bit mr);
        ent_t e;
        if (m_wen) m_rf[m_wdest] = m_wdata;
        last_a_acc = 0; last_m_acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (clock_enable && !wb_hold && mq.size() > 0) begin
                e = mq.pop_front();
                m_wen = 1; m_wdest = e.dest; m_wdata = e.data;
            end else begin
                m_wen = 0;
            end
            if (ar) begin
                e.dest = alu_dest; e.data = alu_data;
                mq.push_back(e); m_lg_mem = 0; last_a_acc = 1;
            end else if (mr) begin
                e.dest = mem_dest; e.data = mem_data;
                mq.push_back(e); m_lg_mem = 1; last_m_acc = 1;
            end
        end
    endtask

    task automatic step_model(string tag);
        bit ar, mr;
        #1;
        ar = exp_ar(); mr = exp_mr();
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(ar));
        chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(mr));
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(m_wen));
        if (m_wen) begin
            chk({tag, ".wr_dest"}, 32'(wr_dest), 32'(m_wdest));
            chk({tag, ".wr_data"}, 32'(wr_data), 32'(m_wdata));
        end
        chk({tag, ".fifo_count"}, 32'(fifo_count), mq.size());
        chk({tag, ".pend_mask"}, 32'(pend_mask), 32'(exp_pend()));
        @(posedge clk);
        model_edge(ar, mr);
        #1;
    endtask

    task automatic step_tab(int k);
        bit ar, mr;
        string t;
        t = $sformatf("vec%0d", k);
        rst = tab[k].rst; clock_enable = tab[k].ce; wb_hold = tab[k].hold;
        alu_valid = tab[k].av; alu_dest = tab[k].ad; alu_data = tab[k].adat;
        mem_valid = tab[k].mv; mem_dest = tab[k].md; mem_data = tab[k].mdat;
        #1;
        ar = exp_ar(); mr = exp_mr();
        chk({t, ".alu_ready"}, 32'(alu_ready), 32'(tab[k].er));
        chk({t, ".mem_ready"}, 32'(mem_ready), 32'(tab[k].em));
        chk({t, ".wr_en"}, 32'(wr_en), 32'(tab[k].ewen));
        chk({t, ".wr_dest"}, 32'(wr_dest), 32'(tab[k].edest));
        chk({t, ".wr_data"}, 32'(wr_data), 32'(tab[k].edata));
        chk({t, ".fifo_count"}, 32'(fifo_count), 32'(tab[k].ecnt));
        chk({t, ".pend_mask"}, 32'(pend_mask), 32'(tab[k].epend));
        @(posedge clk);
        model_edge(ar, mr);
        #1;
    endtask

    task automatic drive(bit av, int ad, int adat, bit mv, int md, int mdat);
        alu_valid = av; alu_dest = 3'(ad); alu_data = 16'(adat);
        mem_valid = mv; mem_dest = 3'(md); mem_data = 16'(mdat);
    endtask

    initial begin
        foreach (m_rf[i]) begin m_rf[i] = '0; dut_rf[i] = '0; end
        rst = 1; clock_enable = 1; wb_hold = 0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        //        rst h av ad adat    mv md mdat    ar mr we wd wdata   cnt pend
        tab[0]  = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      0, 'h00);
        tab[1]  = mk(0, 0, 1, 3, 'hBEEF, 0, 0, 0,      1, 0, 0, 0, 0,      0, 'h00);
        tab[2]  = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      1, 'h08);
        tab[3]  = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 1, 3, 'hBEEF, 0, 'h08);
        tab[4]  = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 3, 'hBEEF, 0, 'h00);
        tab[5]  = mk(1, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 3, 'hBEEF, 0, 'h00);
        tab[6]  = mk(0, 1, 1, 1, 'hA001, 1, 5, 'hB001, 1, 0, 0, 0, 0,      0, 'h00);
        tab[7]  = mk(0, 1, 1, 2, 'hA002, 1, 5, 'hB001, 0, 1, 0, 0, 0,      1, 'h02);
        tab[8]  = mk(0, 1, 1, 2, 'hA002, 1, 6, 'hB002, 1, 0, 0, 0, 0,      2, 'h22);
        tab[9]  = mk(0, 1, 1, 3, 'hA003, 1, 6, 'hB002, 0, 1, 0, 0, 0,      3, 'h26);
        tab[10] = mk(0, 1, 1, 3, 'hA003, 1, 7, 'hB003, 0, 0, 0, 0, 0,      4, 'h66);
        tab[11] = mk(0, 0, 1, 3, 'hA003, 1, 7, 'hB003, 0, 0, 0, 0, 0,      4, 'h66);
        tab[12] = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 1, 1, 'hA001, 3, 'h66);
        tab[13] = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 1, 5, 'hB001, 2, 'h64);
        tab[14] = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 1, 2, 'hA002, 1, 'h44);
        tab[15] = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 1, 6, 'hB002, 0, 'h40);
        tab[16] = mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 6, 'hB002, 0, 'h00);
        for (int k = 0; k < 17; k++) step_tab(k);

        // Two writes to the same register land in acceptance order.
        wb_hold = 1;
        drive(1, 5, 'h5A5A, 0, 0, 0); step_model("dup0");
        drive(1, 5, 'h5B5B, 0, 0, 0); step_model("dup1");
        drive(0, 0, 0, 0, 0, 0);      step_model("dup2");
        wb_hold = 0;
        step_model("dup3");
        step_model("dup4");
        chk("dup.pend5_mid", 32'(pend_mask[5]), 1);
        chk("dup.second_data", 32'(wr_data), 'h5B5B);
        step_model("dup5");
        chk("dup.pend5_end", 32'(pend_mask[5]), 0);
        chk("dup.rf5", 32'(dut_rf[5]), 'h5B5B);

        // Freeze with two entries queued and a third request waiting.
        wb_hold = 1;
        drive(1, 1, 'h1234, 0, 0, 0); step_model("ce0");
        drive(0, 0, 0, 1, 2, 'h5678); step_model("ce1");
        wb_hold = 0; clock_enable = 0;
        drive(1, 3, 'h9ABC, 0, 0, 0);
        for (int i = 0; i < 3; i++) step_model($sformatf("ceoff%0d", i));
        chk("ceoff.count", 32'(fifo_count), 2);
        chk("ceoff.wr_en", 32'(wr_en), 0);
        clock_enable = 1;
        step_model("ceon0");
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 6; i++) step_model($sformatf("ceon%0d", i));
        chk("ceon.rf1", 32'(dut_rf[1]), 'h1234);
        chk("ceon.rf2", 32'(dut_rf[2]), 'h5678);
        chk("ceon.rf3", 32'(dut_rf[3]), 'h9ABC);

        // Reset while three entries are queued and a write is in flight.
        wb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, i + 4, 'hC000 + i, 0, 0, 0);
            step_model($sformatf("rfill%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0);
        wb_hold = 0;
        step_model("rpop");
        chk("rpre.wr_en", 32'(wr_en), 1);
        chk("rpre.count", 32'(fifo_count), 3);
        rst = 1;
        step_model("rst");
        rst = 0;
        chk("rpost.wr_en", 32'(wr_en), 0);
        chk("rpost.count", 32'(fifo_count), 0);
        chk("rpost.pend", 32'(pend_mask), 0);
        drive(1, 1, 'hD001, 1, 2, 'hD002);
        #1;
        chk("rpost.alu_wins", 32'(alu_ready), 1);
        chk("rpost.mem_waits", 32'(mem_ready), 0);
        step_model("rtie");

        // Random traffic; sources hold their request until it is accepted.
        alu_valid = 0; mem_valid = 0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(99) < 2);
            clock_enable = ($urandom_range(99) < 88);
            wb_hold = ($urandom_range(99) < 35);
            if (!alu_valid || last_a_acc) begin
                alu_valid = $urandom_range(1);
                alu_dest = 3'($urandom_range(7));
                alu_data = 16'($urandom);
            end
            if (!mem_valid || last_m_acc) begin
                mem_valid = $urandom_range(1);
                mem_dest = 3'($urandom_range(7));
                mem_data = 16'($urandom);
            end
            step_model("rnd");
        end
        rst = 0; clock_enable = 1; wb_hold = 0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step_model("drain");
        for (int i = 0; i < 8; i++)
            chk($sformatf("rf%0d", i), 32'(dut_rf[i]), 32'(m_rf[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
